seq_frame_tx: RTL and testbench

Serial frame transmitter for the bit-serial sequence link. It accepts a parallel data word over a valid/ready handshake and emits, one bit per clock, a 4-bit sync preamble (1101), the payload MSB-first, an optional parity bit, and then an idle gap. The output feeds the line that the team's 1101 Mealy sequence detector watches, so a receiver detects the frame start on the last sync bit.

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_piso_shreg.sv | 23 ++
 rtl/seq_frame_tx.sv | 114 +++++++++++
 tb/tb_seq_frame_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types, sync preamble defaults and parity helper for the sequence link.
package seq_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;

    localparam int SYNC_W_DEF = 4;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 4'b1101;

    function automatic logic even_parity(input logic [31:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/seq_piso_shreg.sv
// seq_piso_shreg: parallel-load, MSB-first shift register with load and shift enables.
module seq_piso_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (load) q <= d;
        else if (shift) q <= q << 1;
    end

    assign msb = q[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter, sync preamble + MSB-first payload + idle gap.
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx import seq_pkg::*; #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
    parameter int                GAP_LEN  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout,
    output logic              dout_en,
    output logic              frame_done
);

    localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_LEN = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [SYNC_W-1:0] sync_bits;
    logic              accept, data_msb, par_bit;
    logic              dout_n, dout_en_n, done_n;

    assign tx_ready = (state == IDLE) && !rst;
    assign accept   = tx_valid && tx_ready;

    // The payload shifts on every edge that leaves the register holding the next DATA bit.
    seq_piso_shreg #(.W(DATA_W)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (state_n == DATA),
        .d     (tx_data),
        .msb   (data_msb)
    );

`ifdef SEQ_FRAME_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) par_bit <= 1'b0;
        else if (accept) par_bit <= even_parity(32'(tx_data));
    end
`else
    assign par_bit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_n = SYNC;
                    cnt_n   = CNT_W'(SYNC_W - 1);
                end
            end
            SYNC: begin
                state_n = (cnt == '0) ? DATA : SYNC;
                cnt_n   = (cnt == '0) ? CNT_W'(DATA_W - 1) : cnt - 1'b1;
            end
            DATA: begin
`ifdef SEQ_FRAME_TX_PARITY_EN
                state_n = (cnt == '0) ? PAR : DATA;
                cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
`else
                state_n = (cnt == '0) ? GAP : DATA;
                cnt_n   = (cnt == '0) ? CNT_W'(GAP_LEN - 1) : cnt - 1'b1;
`endif
            end
`ifdef SEQ_FRAME_TX_PARITY_EN
            PAR: begin
                state_n = GAP;
                cnt_n   = CNT_W'(GAP_LEN - 1);
            end
`endif
            GAP: begin
                state_n = (cnt == '0) ? IDLE : GAP;
                cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Line outputs are registered alongside the state, so they are derived from the next state.
        sync_bits = SYNC_PAT >> cnt_n;
        dout_n    = (state_n == SYNC) ? sync_bits[0] :
                    (state_n == DATA) ? data_msb :
                    (state_n == PAR)  ? par_bit : 1'b0;
        dout_en_n = (state_n == SYNC) || (state_n == DATA) || (state_n == PAR);
        done_n    = (state_n == GAP) && (state != GAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_en    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            dout       <= dout_n;
            dout_en    <= dout_en_n;
            frame_done <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: randomized scoreboard bench for seq_frame_tx with a timestamped line model.
module tb_seq_frame_tx;

    localparam int DATA_W  = 8;
    localparam int SYNC_W  = 4;
    localparam int GAP_LEN = 2;
`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int PERIOD = SYNC_W + DATA_W + P + GAP_LEN + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready, dout, dout_en, frame_done;

    seq_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .dout       (dout),
        .dout_en    (dout_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   c;
        logic b;
    } bit_t;

    bit_t       bq[$];
    int         fdq[$];
    int         cyc = 0;
    int         vectors = 0;
    int         errors = 0;
    int         ready_at = 0;
    int         det_exp = -1;
    int         det_cnt = 0;
    logic       det_on = 1'b0;
    logic [3:0] hist = '0;
    logic [3:0] sync_pat = 4'b1101;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: an accept at edge k lays out every line bit at its absolute cycle.
    task automatic model_accept(input logic [DATA_W-1:0] w, input int k);
        for (int i = 0; i < SYNC_W; i++) bq.push_back('{k + i, sync_pat[SYNC_W-1-i]});
        for (int i = 0; i < DATA_W; i++) bq.push_back('{k + SYNC_W + i, w[DATA_W-1-i]});
        if (P == 1) bq.push_back('{k + SYNC_W + DATA_W, logic'($countones(w) % 2)});
        fdq.push_back(k + SYNC_W + DATA_W + P);
        ready_at = k + PERIOD - 1;
        if (det_on) det_exp = k + SYNC_W - 1;
    endtask

    always @(negedge clk) begin
        logic exp_en, exp_fd, exp_rdy, det;
        if (cyc > 0) begin
            exp_en = bq.size() > 0 && bq[0].c == cyc;
            check("dout_en", dout_en, exp_en);
            if (exp_en) begin
                check("dout", dout, bq[0].b);
                void'(bq.pop_front());
            end else check("dout_idle", dout, 0);
            exp_fd = fdq.size() > 0 && fdq[0] == cyc;
            check("frame_done", frame_done, exp_fd);
            if (exp_fd) void'(fdq.pop_front());
            exp_rdy = !rst && cyc >= ready_at;
            check("tx_ready", tx_ready, exp_rdy);
            det  = {hist[2:0], dout} == 4'b1101;
            hist = {hist[2:0], dout};
            if (det_on) begin
                check("detect", det, cyc == det_exp);
                det_cnt += int'(det);
            end
            if (rst) begin
                bq.delete();
                fdq.delete();
                ready_at = cyc + 1;
            end else if (tx_valid && exp_rdy) model_accept(tx_data, cyc + 1);
        end
    end

    task automatic wait_ready(output int acc);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            errors++;
            $display("FAIL ready_timeout cyc=%0d got=0 expected=1", cyc);
        end
        acc = cyc + 1;
    endtask

    task automatic send(input logic [DATA_W-1:0] w, output int acc);
        tx_data  = w;
        tx_valid = 1'b1;
        wait_ready(acc);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (PERIOD + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a1, a2;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        send(8'hA5, a1);
        wait_idle();
        send(8'h07, a1);
        wait_idle();
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        wait_ready(a1);
        @(posedge clk);
        #1 tx_data = 8'hFF;
        wait_ready(a2);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check("b2b_period", a2 - a1, PERIOD);
        wait_idle();
        send(8'h5A, a1);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'hC3, a1);
        wait_idle();
        send(8'h3C, a1);
        repeat (PERIOD) begin
            @(posedge clk);
            #1 tx_data = DATA_W'($urandom);
        end
        wait_idle();
        det_on = 1'b1;
        send(8'h00, a1);
        wait_idle();
        det_on = 1'b0;
        check("detect_count", det_cnt, 1);
        repeat (20) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 send(DATA_W'($urandom), a1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1 tx_valid = 1'b1;
                @(posedge clk);
                #1 tx_valid = 1'b0;
            end
        end
        wait_idle();
        check("bits_drained", bq.size(), 0);
        check("done_drained", fdq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
